// File: rtl/ysyx_23060278_mem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
// Request and response channels each use a valid/ready handshake.
interface ysyx_23060278_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wmask, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wmask, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_23060278_mem_responder.sv
// Word-organised data SRAM behind BASE_ADDR answering one load/store per transaction after LATENCY cycles.
// Define YSYX_23060278_MEM_RAND_DELAY_EN to stretch each latency by 0..7 extra cycles from an LFSR.
//
// state | meaning
// IDLE  | ready for a request; accept latches it and loads the delay counter
// WAIT  | delay counter running down; request inputs ignored
// RESP  | response presented and held until rsp_ready
module ysyx_23060278_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1
) (
    input logic                          clk,
    input logic                          rst,
    ysyx_23060278_mem_responder_if.slave bus
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam int          CNT_W    = $clog2(LATENCY + 8);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wen_q;
    logic [3:0]  wmask_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          commit;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic          c_wen;
    logic [3:0]    c_wmask;
    logic          c_in_range;
    logic [AW-1:0] c_idx;

`ifdef YSYX_23060278_MEM_RAND_DELAY_EN
    logic [7:0] lfsr;

    // x^8+x^6+x^5+x^4+1, free-running so the extra delay differs per accept
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 8'hA5;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[2:0]);
`else
    assign cnt_load = CNT_W'(LATENCY - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (cnt_load == '0) ? RESP : WAIT;
            WAIT:    if (cnt <= CNT_W'(1)) state_nxt = RESP;
            RESP:    if (bus.rsp_valid && bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE) && !rst;
        bus.rsp_valid = (state == RESP);
        bus.rsp_rdata = rsp_rdata_q;
        bus.rsp_err   = rsp_err_q;
    end

    assign accept = bus.req_valid && bus.req_ready;

    // A zero-delay accept commits on the accepting edge, before the latches hold the request
    always_comb begin
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_wen   = wen_q;
        c_wmask = wmask_q;
        if (state == IDLE) begin
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
            c_wen   = bus.req_wen;
            c_wmask = bus.req_wmask;
        end
        c_in_range = ({1'b0, c_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, c_addr} < END_ADDR);
        c_idx      = AW'((c_addr - BASE_ADDR) >> 2);
        commit     = (state_nxt == RESP) && (state != RESP) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            wmask_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                wen_q   <= bus.req_wen;
                wmask_q <= bus.req_wmask;
                cnt     <= cnt_load;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                rsp_err_q   <= !c_in_range;
                rsp_rdata_q <= (c_in_range && !c_wen) ? mem[c_idx] : '0;
            end
        end
    end

    // SRAM has no reset; commit already excludes reset so a dropped write never lands
    always_ff @(posedge clk) begin
        if (commit && c_wen && c_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wmask[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060278_mem_responder.sv
// Bench for the data-memory responder: a LATENCY=1 and a LATENCY=4 instance driven from shared stimulus.
// Expected data come from a word-array model updated lane by lane from each write.
module tb_ysyx_23060278_mem_responder;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          LAT_A = 1;
    localparam int          LAT_B = 4;
`ifdef YSYX_23060278_MEM_RAND_DELAY_EN
    localparam int RAND_SPAN = 7;
`else
    localparam int RAND_SPAN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_23060278_mem_responder_if bus_a ();
    ysyx_23060278_mem_responder_if bus_b ();

    ysyx_23060278_mem_responder #(.LATENCY(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    ysyx_23060278_mem_responder #(.LATENCY(LAT_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    logic        sel = 1'b0;
    logic        rv = 1'b0;
    logic        rr = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;

    assign bus_a.req_valid = rv & ~sel;
    assign bus_b.req_valid = rv & sel;
    assign bus_a.rsp_ready = rr & ~sel;
    assign bus_b.rsp_ready = rr & sel;
    assign bus_a.req_addr  = addr;
    assign bus_b.req_addr  = addr;
    assign bus_a.req_wen   = wen;
    assign bus_b.req_wen   = wen;
    assign bus_a.req_wmask = wmask;
    assign bus_b.req_wmask = wmask;
    assign bus_a.req_wdata = wdata;
    assign bus_b.req_wdata = wdata;

    logic        o_req_ready;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    assign o_req_ready = sel ? bus_b.req_ready : bus_a.req_ready;
    assign o_rsp_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    assign o_rsp_rdata = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    assign o_rsp_err   = sel ? bus_b.rsp_err   : bus_a.rsp_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [2][64];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full transaction; ok=0 on timeout or if rsp_valid lingers after the handshake.
    task automatic run_txn(input logic s, input logic w, input logic [31:0] a, input logic [3:0] m,
                           input logic [31:0] d, input int hold, input bit keep_valid,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output bit ok, output bit stable, output bit extra_ready);
        int t;
        ok = 1; stable = 1; extra_ready = 0; lat = 0; rdata = '0; err = 1'b0;
        @(negedge clk);
        sel = s; wen = w; addr = a; wmask = m; wdata = d; rv = 1'b1; rr = 1'b0;
        t = 0;
        while (!o_req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!o_req_ready) begin
            ok = 0;
            rv = 1'b0;
            return;
        end
        @(negedge clk);
        if (!keep_valid) rv = 1'b0;
        addr = $urandom; wdata = $urandom; wmask = 4'($urandom); wen = 1'($urandom);
        lat = 1;
        while (!o_rsp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!o_rsp_valid) begin
            ok = 0;
            rv = 1'b0;
            return;
        end
        rdata = o_rsp_rdata;
        err   = o_rsp_err;
        repeat (hold) begin
            @(negedge clk);
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== rdata || o_rsp_err !== err) stable = 0;
            if (o_req_ready) extra_ready = 1;
        end
        rr = 1'b1;
        @(negedge clk);
        rr = 1'b0;
        rv = 1'b0;
        if (o_rsp_valid !== 1'b0) ok = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_err, bus_b.req_ready, bus_b.rsp_valid, bus_b.rsp_err} !== 6'b0
            || bus_a.rsp_rdata !== 32'h0 || bus_b.rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: a rdy/vld/err=%b%b%b rdata=%h b rdy/vld/err=%b%b%b rdata=%h, expected all 0",
                     bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_err, bus_a.rsp_rdata,
                     bus_b.req_ready, bus_b.rsp_valid, bus_b.rsp_err, bus_b.rsp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_a.req_ready !== 1'b1 || bus_b.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: a=%b b=%b expected 1", bus_a.req_ready, bus_b.req_ready);
        end
    endtask

    task automatic test_basic(input logic s);
        logic [31:0] rd; logic er; int lat, lo; bit ok, st, xr;
        lo = s ? LAT_B : LAT_A;
        run_txn(s, 1'b1, BASE, 4'hF, 32'hDEADBEEF, 0, 0, rd, er, lat, ok, st, xr);
        checks++;
        if (!ok || rd !== 32'h0 || er !== 1'b0) begin
            failures++;
            $display("FAIL basic_write dut%0d: ok=%0d rdata=%h err=%b expected ok=1 rdata=0 err=0", s, ok, rd, er);
        end
        checks++;
        if (lat < lo || lat > lo + RAND_SPAN) begin
            failures++;
            $display("FAIL basic_write_latency dut%0d: got %0d expected %0d..%0d", s, lat, lo, lo + RAND_SPAN);
        end
        run_txn(s, 1'b0, BASE, 4'h0, 32'h0, 1, 0, rd, er, lat, ok, st, xr);
        checks++;
        if (!ok || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            failures++;
            $display("FAIL basic_read dut%0d: ok=%0d rdata=%h err=%b expected rdata=deadbeef err=0", s, ok, rd, er);
        end
        checks++;
        if (lat < lo || lat > lo + RAND_SPAN) begin
            failures++;
            $display("FAIL basic_read_latency dut%0d: got %0d expected %0d..%0d", s, lat, lo, lo + RAND_SPAN);
        end
    endtask

    task automatic test_byte_mask();
        logic [31:0] rd; logic er; int lat; bit ok, st, xr;
        run_txn(1'b0, 1'b1, BASE, 4'b0010, 32'h0000AB00, 0, 0, rd, er, lat, ok, st, xr);
        run_txn(1'b0, 1'b0, BASE, 4'h0, 32'h0, 0, 0, rd, er, lat, ok, st, xr);
        checks++;
        if (!ok || rd !== 32'hDEADABEF || er !== 1'b0) begin
            failures++;
            $display("FAIL lane_write: ok=%0d rdata=%h err=%b expected deadabef err=0", ok, rd, er);
        end
        run_txn(1'b0, 1'b1, BASE + 32'd2, 4'h0, 32'hFFFF_FFFF, 0, 0, rd, er, lat, ok, st, xr);
        checks++;
        if (!ok || rd !== 32'h0 || er !== 1'b0) begin
            failures++;
            $display("FAIL zero_mask_rsp: ok=%0d rdata=%h err=%b expected rdata=0 err=0", ok, rd, er);
        end
        run_txn(1'b0, 1'b0, BASE + 32'd3, 4'h0, 32'h0, 0, 0, rd, er, lat, ok, st, xr);
        checks++;
        if (!ok || rd !== 32'hDEADABEF) begin
            failures++;
            $display("FAIL zero_mask_unchanged: ok=%0d rdata=%h expected deadabef", ok, rd);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd; logic er; int lat; bit ok, st, xr;
        run_txn(1'b0, 1'b1, BASE + 32'h3FFC, 4'hF, 32'hCAFEF00D, 0, 0, rd, er, lat, ok, st, xr);
        run_txn(1'b0, 1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0, 0, 0, rd, er, lat, ok, st, xr);
        checks++;
        if (!ok || rd !== 32'h0 || er !== 1'b1) begin
            failures++;
            $display("FAIL below_base_read: ok=%0d rdata=%h err=%b expected rdata=0 err=1", ok, rd, er);
        end
        run_txn(1'b0, 1'b1, BASE + 32'h4000, 4'hF, 32'h1234_5678, 0, 0, rd, er, lat, ok, st, xr);
        checks++;
        if (!ok || rd !== 32'h0 || er !== 1'b1) begin
            failures++;
            $display("FAIL past_end_write: ok=%0d rdata=%h err=%b expected rdata=0 err=1", ok, rd, er);
        end
        run_txn(1'b0, 1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0, 0, 0, rd, er, lat, ok, st, xr);
        checks++;
        if (!ok || rd !== 32'h0 || er !== 1'b1) begin
            failures++;
            $display("FAIL top_addr_read: ok=%0d rdata=%h err=%b expected rdata=0 err=1", ok, rd, er);
        end
        run_txn(1'b0, 1'b0, BASE + 32'h3FFC, 4'h0, 32'h0, 0, 0, rd, er, lat, ok, st, xr);
        checks++;
        if (!ok || rd !== 32'hCAFEF00D || er !== 1'b0) begin
            failures++;
            $display("FAIL last_word_intact: ok=%0d rdata=%h err=%b expected cafef00d err=0", ok, rd, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; bit ok, st, xr;
        run_txn(1'b1, 1'b1, BASE + 32'd8, 4'hF, 32'h5A5AC3C3, 0, 0, rd, er, lat, ok, st, xr);
        run_txn(1'b1, 1'b0, BASE + 32'd8, 4'h0, 32'h0, 5, 1, rd, er, lat, ok, st, xr);
        checks++;
        if (!ok || rd !== 32'h5A5AC3C3 || er !== 1'b0) begin
            failures++;
            $display("FAIL held_rsp_data: ok=%0d rdata=%h err=%b expected 5a5ac3c3 err=0", ok, rd, er);
        end
        checks++;
        if (!st || xr) begin
            failures++;
            $display("FAIL held_rsp_stable: stable=%0d ready_seen=%0d expected stable=1 ready_seen=0", st, xr);
        end
        run_txn(1'b1, 1'b1, BASE + 32'd8, 4'b1000, 32'h7700_0000, 0, 0, rd, er, lat, ok, st, xr);
        run_txn(1'b1, 1'b0, BASE + 32'd8, 4'h0, 32'h0, 0, 0, rd, er, lat, ok, st, xr);
        checks++;
        if (!ok || rd !== 32'h775AC3C3) begin
            failures++;
            $display("FAIL after_hold_txn: ok=%0d rdata=%h expected 775ac3c3", ok, rd);
        end
    endtask

    task automatic test_reset_mid_txn();
        logic [31:0] rd; logic er; int lat, t; bit ok, st, xr, seen_valid;
        run_txn(1'b1, 1'b1, BASE + 32'h10, 4'hF, 32'h1111_1111, 0, 0, rd, er, lat, ok, st, xr);
        @(negedge clk);
        sel = 1'b1; wen = 1'b1; addr = BASE + 32'h10; wmask = 4'hF; wdata = 32'h2222_2222; rv = 1'b1;
        t = 0;
        while (!o_req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        rv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_wait: rsp_valid=%b req_ready=%b expected 0 0", o_rsp_valid, o_req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_rsp_valid !== 1'b0) seen_valid = 1;
        end
        checks++;
        if (seen_valid) begin
            failures++;
            $display("FAIL dropped_txn_rsp: rsp_valid rose after reset, expected none");
        end
        run_txn(1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0, 0, 0, rd, er, lat, ok, st, xr);
        checks++;
        if (!ok || rd !== 32'h1111_1111) begin
            failures++;
            $display("FAIL dropped_write: ok=%0d rdata=%h expected 11111111", ok, rd);
        end
    endtask

    task automatic test_random(input logic s, input int n);
        logic [31:0] rd, a, d, exp_rd; logic er, w, inr, exp_er; logic [3:0] m;
        int lat, lo, idx, hold; bit ok, st, xr; logic [7:0] seen;
        lo = s ? LAT_B : LAT_A;
        seen = '0;
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            run_txn(s, 1'b1, BASE + 32'(4 * i), 4'hF, d, 0, 0, rd, er, lat, ok, st, xr);
            model[s][i] = d;
            checks++;
            if (!ok || er !== 1'b0) begin
                failures++;
                $display("FAIL rand_init dut%0d word %0d: ok=%0d err=%b expected ok=1 err=0", s, i, ok, er);
            end
        end
        for (int k = 0; k < n; k++) begin
            w = 1'($urandom_range(0, 1)); m = 4'($urandom); d = $urandom;
            idx = int'($urandom_range(0, 63)); hold = int'($urandom_range(0, 3));
            inr = ($urandom_range(0, 15) != 0);
            if (inr) a = BASE + 32'(4 * idx) + 32'($urandom_range(0, 3));
            else begin
                case ($urandom_range(0, 2))
                    0:       a = BASE - 32'(4 * $urandom_range(1, 64));
                    1:       a = BASE + 32'h4000 + 32'($urandom_range(0, 255));
                    default: a = 32'hFFFF_FFFC;
                endcase
            end
            exp_er = !inr;
            exp_rd = (inr && !w) ? model[s][idx] : 32'h0;
            run_txn(s, w, a, m, d, hold, 0, rd, er, lat, ok, st, xr);
            if (inr && w) begin
                for (int b = 0; b < 4; b++) if (m[b]) model[s][idx][8*b +: 8] = d[8*b +: 8];
            end
            checks++;
            if (!ok || !st) begin
                failures++;
                $display("FAIL rand_handshake dut%0d txn %0d: ok=%0d stable=%0d expected 1 1", s, k, ok, st);
            end
            checks++;
            if (rd !== exp_rd || er !== exp_er) begin
                failures++;
                $display("FAIL rand_data dut%0d txn %0d addr=%h wen=%b: rdata=%h err=%b expected rdata=%h err=%b",
                         s, k, a, w, rd, er, exp_rd, exp_er);
            end
            checks++;
            if (lat < lo || lat > lo + RAND_SPAN) begin
                failures++;
                $display("FAIL rand_latency dut%0d txn %0d: got %0d expected %0d..%0d", s, k, lat, lo, lo + RAND_SPAN);
            end
            if (lat >= lo && lat <= lo + 7) seen[lat - lo] = 1'b1;
        end
`ifdef YSYX_23060278_MEM_RAND_DELAY_EN
        checks++;
        if ($countones(seen) < 4) begin
            failures++;
            $display("FAIL rand_latency_spread dut%0d: distinct=%0d expected >=4", s, $countones(seen));
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_byte_mask();
        test_range();
        test_back_to_back();
        test_reset_mid_txn();
        test_random(1'b0, 1000);
        test_random(1'b1, 300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
